spiking_layer: RTL and testbench
================================

SPIKING_LAYER -- requirements
Module: spiking_layer

Interface
REQ-001 SHALL have parameter N_IN, default 4, number of input spike lines.
REQ-002 SHALL have parameter N_OUT, default 2, number of LIF neurons and output spike lines.
REQ-003 SHALL have parameter W_BITS, default 4, signed two's-complement synaptic weight width.
REQ-004 SHALL have parameter V_BITS, default 8, signed two's-complement membrane potential width.
REQ-005 SHALL have parameter N_CYCLES, default 10, number of timesteps per inference window (legal range 1..2^CNT_BITS-1).
REQ-006 SHALL have parameter CNT_BITS, default 5, width of the timestep counter and of each per-neuron spike counter.
REQ-007 SHALL have parameter THRESHOLD, default 8, firing threshold (legal range 1..2^(V_BITS-1)-1).
REQ-008 SHALL have parameter LEAK_SHIFT, default 2, leak as arithmetic right-shift amount.
REQ-009 SHALL have parameter RESET_MODE, default 0, post-spike reset: 0 = set membrane to 0, 1 = subtract THRESHOLD.
REQ-010 SHALL have port clk, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-011 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-012 SHALL have port start, input, 1 bit, starts an inference window when accepted.
REQ-013 SHALL have port ready, output, 1 bit, high only in IDLE.
REQ-014 SHALL have port sample, output, 1 bit, request for a new input vector.
REQ-015 SHALL have port sample_ready, input, 1 bit, input vector valid on in_spikes.
REQ-016 SHALL have port in_spikes, input, N_IN bits, input spike vector.
REQ-017 SHALL have port weights, input, N_IN*N_OUT*W_BITS bits; weight (i,j) for input i to neuron j occupies slice [(j*N_IN+i)*W_BITS +: W_BITS]; held static during a window.
REQ-018 SHALL have port out_spikes, output, N_OUT bits, registered spikes of the latest timestep.
REQ-019 SHALL have port spike_counts, output, N_OUT*CNT_BITS bits, per-neuron spike totals of the window; neuron j at [j*CNT_BITS +: CNT_BITS].
REQ-020 SHALL have port done, output, 1 bit, one-cycle pulse at window end.

Function
REQ-021 SHALL implement FSM states IDLE, SAMPLE, UPDATE, DONE.
REQ-022 IDLE: ready=1; start=1 -> SAMPLE next cycle, clearing all membranes, spike_counts, out_spikes and timestep counter on that edge.
REQ-023 SAMPLE: sample=1 held until sample_ready=1; on the edge where sample=1 and sample_ready=1, in_spikes SHALL be captured and FSM -> UPDATE.
REQ-024 sample_ready low SHALL stall indefinitely in SAMPLE with no membrane change (no leak during stall).
REQ-025 UPDATE (one cycle): per neuron j, v_next = v - (v >>> LEAK_SHIFT) + sum of weight(i,j) over captured bits i=1, computed at width sufficient to avoid overflow, then saturated to [-2^(V_BITS-1), 2^(V_BITS-1)-1].
REQ-026 If saturated v_next >= THRESHOLD, out_spikes[j] SHALL be 1 and membrane SHALL take the RESET_MODE value; else out_spikes[j]=0 and membrane = v_next.
REQ-027 Each spike SHALL increment spike_counts[j], saturating at 2^CNT_BITS-1.
REQ-028 UPDATE SHALL increment the timestep counter; if new count equals N_CYCLES -> DONE, else -> SAMPLE.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE; spike_counts and out_spikes SHALL hold until the next accepted start.
REQ-030 Minimum timestep latency SHALL be 2 cycles (SAMPLE with sample_ready=1, then UPDATE); window minimum 2*N_CYCLES+1 cycles from start acceptance to done.
REQ-031 start outside IDLE SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-032 sample and ready SHALL never be high simultaneously.

Reset
REQ-033 rst=1 SHALL asynchronously force IDLE, ready=1, sample=0, done=0, out_spikes=0, spike_counts=0, membranes=0, counter=0, including mid-window.

Verification
REQ-034 Defaults, neuron0 weights all +3, neuron1 all -1, in_spikes=4'hF every step, sample_ready=1 -> out_spikes=2'b01 each timestep, done after 21 cycles, spike_counts: neuron0=10, neuron1=0.
REQ-035 Same, sample_ready low 5 cycles during step 3 -> sample stays high, membranes unchanged, done 5 cycles later, counts identical.
REQ-036 V_BITS=6, THRESHOLD=31, neuron0 weights +7, in_spikes=4'hF -> step1 v=28 no spike; step2 v saturates 31, spike.
REQ-037 RESET_MODE=1, neuron0 weights +3, in_spikes=4'hF -> step1 v=12 spike, membrane 4; step2 v=4-1+12=15 spike, membrane 7.
REQ-038 rst pulse during step 5 -> same cycle ready=1, sample=0, out_spikes=0, spike_counts=0; new start runs full window normally.
REQ-039 start held high through a window -> ignored while busy; new window begins the cycle after IDLE is reentered.

Source files
------------

// File: rtl/spiking_layer.sv
// Layer of leaky integrate-and-fire neurons driven by a sampled input spike vector.
// Each inference window runs N_CYCLES sample/update timesteps and reports per-neuron spike totals.
module spiking_layer #(
    parameter int N_IN       = 4,
    parameter int N_OUT      = 2,
    parameter int W_BITS     = 4,
    parameter int V_BITS     = 8,
    parameter int N_CYCLES   = 10,
    parameter int CNT_BITS   = 5,
    parameter int THRESHOLD  = 8,
    parameter int LEAK_SHIFT = 2,
    parameter int RESET_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         ready,
    output logic                         sample,
    input  logic                         sample_ready,
    input  logic [N_IN-1:0]              in_spikes,
    input  logic [N_IN*N_OUT*W_BITS-1:0] weights,
    output logic [N_OUT-1:0]             out_spikes,
    output logic [N_OUT*CNT_BITS-1:0]    spike_counts,
    output logic                         done
);

    // Accumulator is wide enough for membrane, leak and a full weight sum without overflow.
    localparam int ACC_BITS = V_BITS + W_BITS + $clog2(N_IN + 1) + 1;
    localparam logic signed [ACC_BITS-1:0] V_MAX_A = ACC_BITS'((64'sd1 <<< (V_BITS - 1)) - 64'sd1);
    localparam logic signed [ACC_BITS-1:0] V_MIN_A = ~V_MAX_A;
    localparam logic signed [V_BITS-1:0]   THR_V   = V_BITS'(THRESHOLD);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] N_CYC_C  = CNT_BITS'(N_CYCLES);
    localparam bit                  SUB_RESET = (RESET_MODE != 32'sd0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                      state_r;
    state_t                      state_next_s;
    logic [CNT_BITS-1:0]         step_r;
    logic [CNT_BITS-1:0]         step_inc_s;
    logic [N_IN-1:0]             spikes_r;
    logic signed [V_BITS-1:0]    v_r      [N_OUT];
    logic signed [ACC_BITS-1:0]  acc_s    [N_OUT];
    logic signed [V_BITS-1:0]    v_next_s [N_OUT];
    logic signed [V_BITS-1:0]    v_post_s [N_OUT];
    logic [N_OUT-1:0]            fire_s;
    logic [CNT_BITS-1:0]         cnt_r    [N_OUT];
    logic [N_OUT-1:0]            out_r;
    logic                        ready_r;
    logic                        sample_r;
    logic                        done_r;

    function automatic logic signed [V_BITS-1:0] sat_v(input logic signed [ACC_BITS-1:0] a);
        if (a > V_MAX_A) begin
            return V_MAX_A[V_BITS-1:0];
        end else if (a < V_MIN_A) begin
            return V_MIN_A[V_BITS-1:0];
        end else begin
            return a[V_BITS-1:0];
        end
    endfunction

    assign step_inc_s = step_r + CNT_ONE;

    // Next-state decode of the window sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = SAMPLE;
                else       state_next_s = IDLE;
            end
            SAMPLE: begin
                if (sample_ready) state_next_s = UPDATE;
                else              state_next_s = SAMPLE;
            end
            UPDATE: begin
                if (step_inc_s == N_CYC_C) state_next_s = DONE;
                else                       state_next_s = SAMPLE;
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register plus handshake outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            ready_r  <= 1'b1;
            sample_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            ready_r  <= (state_next_s == IDLE);
            sample_r <= (state_next_s == SAMPLE);
            done_r   <= (state_next_s == DONE);
        end
    end

    // Leak, integrate, saturate and fire for every neuron from the captured input vector.
    always_comb begin
        fire_s = '0;
        for (int j = 0; j < N_OUT; j++) begin
            acc_s[j] = ACC_BITS'(v_r[j]) - ACC_BITS'(v_r[j] >>> LEAK_SHIFT);
            for (int i = 0; i < N_IN; i++) begin
                if (spikes_r[i]) begin
                    acc_s[j] = acc_s[j] + ACC_BITS'($signed(weights[(j*N_IN+i)*W_BITS +: W_BITS]));
                end else begin
                    acc_s[j] = acc_s[j];
                end
            end
            v_next_s[j] = sat_v(acc_s[j]);
            fire_s[j]   = (v_next_s[j] >= THR_V);
            if (fire_s[j]) begin
                v_post_s[j] = SUB_RESET ? (v_next_s[j] - THR_V) : '0;
            end else begin
                v_post_s[j] = v_next_s[j];
            end
        end
    end

    // Datapath registers: cleared on accepted start, loaded on capture and update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_r   <= '0;
            spikes_r <= '0;
            out_r    <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                v_r[j]   <= '0;
                cnt_r[j] <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        step_r <= '0;
                        out_r  <= '0;
                        for (int j = 0; j < N_OUT; j++) begin
                            v_r[j]   <= '0;
                            cnt_r[j] <= '0;
                        end
                    end
                end
                SAMPLE: begin
                    if (sample_ready) spikes_r <= in_spikes;
                end
                UPDATE: begin
                    step_r <= step_inc_s;
                    out_r  <= fire_s;
                    for (int j = 0; j < N_OUT; j++) begin
                        v_r[j] <= v_post_s[j];
                        if (fire_s[j] && (cnt_r[j] != CNT_MAX)) cnt_r[j] <= cnt_r[j] + CNT_ONE;
                    end
                end
                default: begin
                    step_r <= step_r;
                end
            endcase
        end
    end

    // Pack per-neuron counters onto the flat output bus.
    always_comb begin
        spike_counts = '0;
        for (int j = 0; j < N_OUT; j++) begin
            spike_counts[j*CNT_BITS +: CNT_BITS] = cnt_r[j];
        end
    end

    assign ready      = ready_r;
    assign sample     = sample_r;
    assign done       = done_r;
    assign out_spikes = out_r;

endmodule

// File: tb/tb_spiking_layer.sv
// Bench for spiking_layer: three parameterisations share one stimulus stream and are
// compared against a timestep-level arithmetic model of the LIF layer.
module tb_spiking_layer;

    localparam int NU = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sample_ready;
    logic [3:0] in_spikes;
    logic [31:0] weights;
    logic [2:0] rdy, smp, dn;
    logic [1:0] outs [NU];
    logic [9:0] cnts [NU];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    int vbits [NU] = '{8, 6, 8};
    int thr   [NU] = '{8, 31, 8};
    int rmode [NU] = '{0, 0, 1};
    int mv [NU][2];
    int mc [NU][2];
    int mo [NU][2];
    int w  [4][2];

    always #5 clk = ~clk;

    spiking_layer u_def (
        .clk(clk), .rst(rst), .start(start), .ready(rdy[0]), .sample(smp[0]),
        .sample_ready(sample_ready), .in_spikes(in_spikes), .weights(weights),
        .out_spikes(outs[0]), .spike_counts(cnts[0]), .done(dn[0]));

    spiking_layer #(.V_BITS(6), .THRESHOLD(31)) u_sat (
        .clk(clk), .rst(rst), .start(start), .ready(rdy[1]), .sample(smp[1]),
        .sample_ready(sample_ready), .in_spikes(in_spikes), .weights(weights),
        .out_spikes(outs[1]), .spike_counts(cnts[1]), .done(dn[1]));

    spiking_layer #(.RESET_MODE(1)) u_sub (
        .clk(clk), .rst(rst), .start(start), .ready(rdy[2]), .sample(smp[2]),
        .sample_ready(sample_ready), .in_spikes(in_spikes), .weights(weights),
        .out_spikes(outs[2]), .spike_counts(cnts[2]), .done(dn[2]));

    // sample and ready must never be high together
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ((smp & rdy) !== 3'b000) begin
                errors++;
                $display("FAIL sample_ready_excl got smp=%b rdy=%b want no overlap", smp, rdy);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_weights(input int a0, input int a1);
        for (int i = 0; i < 4; i++) begin
            w[i][0] = a0;
            w[i][1] = a1;
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 2; j++)
                weights[(j*4+i)*4 +: 4] = 4'(w[i][j]);
    endtask

    task automatic rand_weights();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 2; j++) begin
                w[i][j] = int'($urandom_range(0, 15)) - 8;
                weights[(j*4+i)*4 +: 4] = 4'(w[i][j]);
            end
    endtask

    task automatic model_clear();
        for (int u = 0; u < NU; u++)
            for (int j = 0; j < 2; j++) begin
                mv[u][j] = 0;
                mc[u][j] = 0;
                mo[u][j] = 0;
            end
    endtask

    task automatic model_step(input logic [3:0] sp);
        int sum, vn, vmax, vmin;
        for (int u = 0; u < NU; u++) begin
            vmax = (1 << (vbits[u] - 1)) - 1;
            vmin = -(1 << (vbits[u] - 1));
            for (int j = 0; j < 2; j++) begin
                sum = 0;
                for (int i = 0; i < 4; i++)
                    if (sp[i]) sum += w[i][j];
                vn = mv[u][j] - (mv[u][j] >>> 2) + sum;
                if (vn > vmax) vn = vmax;
                if (vn < vmin) vn = vmin;
                if (vn >= thr[u]) begin
                    mo[u][j] = 1;
                    if (mc[u][j] < 31) mc[u][j]++;
                    mv[u][j] = (rmode[u] == 1) ? vn - thr[u] : 0;
                end else begin
                    mo[u][j] = 0;
                    mv[u][j] = vn;
                end
            end
        end
    endtask

    function automatic logic [5:0] exp_outs();
        logic [5:0] r;
        for (int u = 0; u < NU; u++)
            for (int j = 0; j < 2; j++) r[u*2+j] = (mo[u][j] != 0);
        return r;
    endfunction

    function automatic logic [29:0] exp_cnts();
        logic [29:0] r;
        for (int u = 0; u < NU; u++)
            for (int j = 0; j < 2; j++) r[(u*2+j)*5 +: 5] = 5'(mc[u][j]);
        return r;
    endfunction

    function automatic logic [5:0] act_outs();
        return {outs[2], outs[1], outs[0]};
    endfunction

    function automatic logic [29:0] act_cnts();
        return {cnts[2], cnts[1], cnts[0]};
    endfunction

    task automatic accept_start(input bit hold);
        start = 1'b1;
        cyc = 0;
        tick();
        start = hold;
        model_clear();
    endtask

    // one timestep with an optional stall, ending just after the update edge
    task automatic do_step(input logic [3:0] sp, input int stall);
        sample_ready = 1'b0;
        for (int k = 0; k < stall; k++) tick();
        sample_ready = 1'b1;
        in_spikes = sp;
        tick();
        sample_ready = 1'b0;
        in_spikes = 4'($urandom);
        tick();
        model_step(sp);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (rdy !== 3'b111 || smp !== 3'b000 || dn !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b smp=%b dn=%b want 111/000/000", rdy, smp, dn);
        end
        checks++;
        if (act_outs() !== 6'd0 || act_cnts() !== 30'd0) begin
            errors++;
            $display("FAIL reset_data got outs=%h cnts=%h want 0/0", act_outs(), act_cnts());
        end
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        tick();
        checks++;
        if (rdy !== 3'b111 || smp !== 3'b000) begin
            errors++;
            $display("FAIL idle_no_start got rdy=%b smp=%b want 111/000", rdy, smp);
        end
    endtask

    task automatic test_basic();
        set_weights(3, -1);
        accept_start(1'b0);
        checks++;
        if (smp !== 3'b111 || rdy !== 3'b000 || act_cnts() !== 30'd0) begin
            errors++;
            $display("FAIL basic_accept got smp=%b rdy=%b cnts=%h want 111/000/0", smp, rdy, act_cnts());
        end
        for (int s = 1; s <= 10; s++) begin
            do_step(4'hF, 0);
            checks++;
            if (act_outs() !== exp_outs() || outs[0] !== 2'b01) begin
                errors++;
                $display("FAIL basic_step%0d got %b want %b", s, act_outs(), exp_outs());
            end
            checks++;
            if (dn !== ((s == 10) ? 3'b111 : 3'b000)) begin
                errors++;
                $display("FAIL basic_done_step%0d got %b", s, dn);
            end
        end
        checks++;
        if (cyc !== 21) begin
            errors++;
            $display("FAIL basic_latency got %0d want 21", cyc);
        end
        tick();
        checks++;
        if (dn !== 3'b000 || rdy !== 3'b111 || act_cnts() !== exp_cnts() || cnts[0] !== {5'd0, 5'd10}) begin
            errors++;
            $display("FAIL basic_end got dn=%b rdy=%b cnts=%h want cnts=%h", dn, rdy, act_cnts(), exp_cnts());
        end
        tick();
        checks++;
        if (act_cnts() !== exp_cnts() || act_outs() !== exp_outs()) begin
            errors++;
            $display("FAIL basic_hold got %h want %h", act_cnts(), exp_cnts());
        end
    endtask

    task automatic test_stall();
        logic [5:0] o_before;
        logic [29:0] c_before;
        set_weights(3, -1);
        accept_start(1'b0);
        do_step(4'hF, 0);
        do_step(4'hF, 0);
        o_before = act_outs();
        c_before = act_cnts();
        sample_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (smp !== 3'b111 || act_outs() !== o_before || act_cnts() !== c_before) begin
                errors++;
                $display("FAIL stall_cycle%0d got smp=%b outs=%b want 111/%b", k, smp, act_outs(), o_before);
            end
        end
        for (int s = 3; s <= 10; s++) begin
            do_step(4'hF, 0);
            checks++;
            if (act_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL stall_step%0d got %b want %b", s, act_outs(), exp_outs());
            end
        end
        checks++;
        if (dn !== 3'b111 || cyc !== 26 || cnts[0] !== {5'd0, 5'd10}) begin
            errors++;
            $display("FAIL stall_done got dn=%b cyc=%0d cnts=%h want 111/26/00a", dn, cyc, cnts[0]);
        end
        tick();
    endtask

    task automatic test_saturate();
        set_weights(7, 0);
        accept_start(1'b0);
        for (int s = 1; s <= 10; s++) begin
            do_step(4'hF, 0);
            checks++;
            if (act_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL sat_step%0d got %b want %b", s, act_outs(), exp_outs());
            end
            if (s <= 2) begin
                checks++;
                if (outs[1][0] !== ((s == 2) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL sat_v6_step%0d got %b", s, outs[1][0]);
                end
            end
        end
        checks++;
        if (act_cnts() !== exp_cnts()) begin
            errors++;
            $display("FAIL sat_counts got %h want %h", act_cnts(), exp_cnts());
        end
        tick();
    endtask

    task automatic test_reset_mode();
        set_weights(1, 3);
        accept_start(1'b0);
        for (int s = 1; s <= 10; s++) begin
            do_step(4'hF, 0);
            checks++;
            if (act_outs() !== exp_outs()) begin
                errors++;
                $display("FAIL rmode_step%0d got %b want %b", s, act_outs(), exp_outs());
            end
        end
        checks++;
        if (act_cnts() !== exp_cnts() || cnts[2][9:5] !== 5'd10) begin
            errors++;
            $display("FAIL rmode_counts got %h want %h", act_cnts(), exp_cnts());
        end
        tick();
    endtask

    task automatic test_random();
        for (int win = 0; win < 6; win++) begin
            int stalls = 0;
            int st;
            rand_weights();
            accept_start(1'b0);
            for (int s = 1; s <= 10; s++) begin
                st = int'($urandom_range(0, 2));
                stalls += st;
                do_step(4'($urandom), st);
                checks++;
                if (act_outs() !== exp_outs()) begin
                    errors++;
                    $display("FAIL rand_w%0d_s%0d got %b want %b", win, s, act_outs(), exp_outs());
                end
            end
            checks++;
            if (dn !== 3'b111 || cyc !== 21 + stalls || act_cnts() !== exp_cnts()) begin
                errors++;
                $display("FAIL rand_w%0d_end got dn=%b cyc=%0d cnts=%h want cyc=%0d cnts=%h",
                         win, dn, cyc, act_cnts(), 21 + stalls, exp_cnts());
            end
            tick();
        end
    endtask

    task automatic test_midreset();
        set_weights(3, -1);
        accept_start(1'b0);
        for (int s = 1; s <= 4; s++) do_step(4'hF, 0);
        sample_ready = 1'b0;
        tick();
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (rdy !== 3'b111 || smp !== 3'b000 || dn !== 3'b000 ||
            act_outs() !== 6'd0 || act_cnts() !== 30'd0) begin
            errors++;
            $display("FAIL midreset got rdy=%b smp=%b outs=%b cnts=%h want 111/000/0/0",
                     rdy, smp, act_outs(), act_cnts());
        end
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        tick();
        accept_start(1'b0);
        for (int s = 1; s <= 10; s++) do_step(4'hF, 0);
        checks++;
        if (dn !== 3'b111 || cyc !== 21 || act_cnts() !== exp_cnts() || cnts[0] !== {5'd0, 5'd10}) begin
            errors++;
            $display("FAIL midreset_rerun got dn=%b cyc=%0d cnts=%h want 111/21/%h", dn, cyc, act_cnts(), exp_cnts());
        end
        tick();
    endtask

    task automatic test_hold_start();
        set_weights(3, -1);
        accept_start(1'b1);
        for (int s = 1; s <= 10; s++) do_step(4'hF, 0);
        checks++;
        if (dn !== 3'b111 || cyc !== 21) begin
            errors++;
            $display("FAIL hold_done got dn=%b cyc=%0d want 111/21", dn, cyc);
        end
        tick();
        checks++;
        if (rdy !== 3'b111 || smp !== 3'b000 || act_cnts() !== exp_cnts()) begin
            errors++;
            $display("FAIL hold_idle got rdy=%b smp=%b cnts=%h want 111/000/%h", rdy, smp, act_cnts(), exp_cnts());
        end
        accept_start(1'b0);
        checks++;
        if (smp !== 3'b111 || act_cnts() !== 30'd0 || act_outs() !== 6'd0) begin
            errors++;
            $display("FAIL hold_restart got smp=%b cnts=%h outs=%b want 111/0/0", smp, act_cnts(), act_outs());
        end
        for (int s = 1; s <= 10; s++) do_step(4'hF, 0);
        checks++;
        if (dn !== 3'b111 || act_cnts() !== exp_cnts()) begin
            errors++;
            $display("FAIL hold_second got dn=%b cnts=%h want 111/%h", dn, act_cnts(), exp_cnts());
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        sample_ready = 1'b0;
        in_spikes = 4'h0;
        weights = 32'h0;
        model_clear();
        test_reset();
        test_basic();
        test_stall();
        test_saturate();
        test_reset_mode();
        test_random();
        test_midreset();
        test_hold_start();
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
